// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared constants and clear-sequencer state type for the byte RAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_clear_seq.sv
// ============================================================================
// Module  : mem_clear_seq
// Brief   : Post-reset sequencer that zeroes the byte array BYTES bytes/cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int CLEAR_EN = 1,
    parameter int ADDR_W   = 16,
    parameter int BYTES    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam mem_state_t      RST_STATE = (CLEAR_EN != 0) ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_W:0] LAST_PTR  = (ADDR_W+1)'((2 ** ADDR_W) - BYTES);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(BYTES);
                // The cycle that writes the top word is the last clear cycle.
                if ({1'b0, ptr_q} >= LAST_PTR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = RST_STATE;
        endcase
    end

    always_comb begin
        busy     = (state_q == ST_CLEAR);
        clr_we   = (state_q == ST_CLEAR);
        clr_addr = ptr_q;
    end

endmodule

`default_nettype wire

// File: rtl/mem_dp_byte_sync.sv
// ============================================================================
// Module  : mem_dp_byte_sync
// Brief   : Dual-port big-endian byte RAM, registered read-first reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_dp_byte_sync
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int CLEAR_EN = 1,
    parameter int PRIO_A   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [DATA_W/8-1:0]   b_be,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_rvalid,
    output logic                  busy,
    inout  wire                   dvdd,
    inout  wire                   dgnd
);

    localparam int BYTES = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [BYTE_W-1:0] mem [0:DEPTH-1];

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_a_acc, w_b_acc;
    logic              w_unused_pwr;

    logic              w_lo_we, w_hi_we;
    logic [BYTES-1:0]  w_lo_be, w_hi_be;
    logic [ADDR_W-1:0] w_lo_addr, w_hi_addr;
    logic [DATA_W-1:0] w_lo_wdata, w_hi_wdata;

    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;

    assign w_unused_pwr = dvdd ^ dgnd;

    mem_clear_seq #(
        .CLEAR_EN (CLEAR_EN),
        .ADDR_W   (ADDR_W),
        .BYTES    (BYTES)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign w_a_acc = a_req && !busy;
    assign w_b_acc = b_req && !busy;

    // The "hi" port is written last so it wins any lane both ports touch.
    always_comb begin
        if (PRIO_A != 0) begin
            w_lo_we = w_b_acc && b_we;  w_lo_be = b_be;  w_lo_addr = b_addr;  w_lo_wdata = b_wdata;
            w_hi_we = w_a_acc && a_we;  w_hi_be = a_be;  w_hi_addr = a_addr;  w_hi_wdata = a_wdata;
        end else begin
            w_lo_we = w_a_acc && a_we;  w_lo_be = a_be;  w_lo_addr = a_addr;  w_lo_wdata = a_wdata;
            w_hi_we = w_b_acc && b_we;  w_hi_be = b_be;  w_hi_addr = b_addr;  w_hi_wdata = b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            for (int k = 0; k < BYTES; k++) begin
                mem[w_clr_addr + ADDR_W'(k)] <= '0;
            end
        end else begin
            for (int k = 0; k < BYTES; k++) begin
                if (w_lo_we && w_lo_be[BYTES-1-k]) begin
                    mem[w_lo_addr + ADDR_W'(k)] <= w_lo_wdata[DATA_W-1-BYTE_W*k -: BYTE_W];
                end
            end
            for (int k = 0; k < BYTES; k++) begin
                if (w_hi_we && w_hi_be[BYTES-1-k]) begin
                    mem[w_hi_addr + ADDR_W'(k)] <= w_hi_wdata[DATA_W-1-BYTE_W*k -: BYTE_W];
                end
            end
        end
    end

    // Reads sample the array before this edge's writes land: read-first.
    always_comb begin
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_rvalid_d = w_a_acc && !a_we;
        b_rvalid_d = w_b_acc && !b_we;
        if (a_rvalid_d) begin
            for (int k = 0; k < BYTES; k++) begin
                a_rdata_d[DATA_W-1-BYTE_W*k -: BYTE_W] = mem[a_addr + ADDR_W'(k)];
            end
        end
        if (b_rvalid_d) begin
            for (int k = 0; k < BYTES; k++) begin
                b_rdata_d[DATA_W-1-BYTE_W*k -: BYTE_W] = mem[b_addr + ADDR_W'(k)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;

endmodule

`default_nettype wire
